// File: rtl/utterance_capture_ctrl.sv
// utterance_capture_ctrl
//   Sequencer between the voice-activity detector and the audio ring buffer.
//   Every incoming sample is written into the ring. A rising edge of
//   speech_detected opens an utterance that reaches up to PRE_SAMPLES back
//   into the history. A falling edge, or the MAX_SAMPLES cap, closes it. A
//   closed utterance is replayed from the ring over a valid/ready stream.
//   Utterances shorter than MIN_SAMPLES are discarded.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_valid        one-cycle strobe per audio sample
//   audio_in[15:0]      signed PCM sample
//   speech_detected     VAD decision (with hangover)
//   mem_we/waddr/wdata  ring write port (combinational from sample_valid)
//   mem_re/raddr        ring read request
//   mem_rdata[15:0]     ring read data, valid one cycle after mem_re
//   out_valid/data/last utterance stream; out_ready is the consumer accept
//   busy                high in CAPTURE or DRAIN
//   utt_drop            one-cycle pulse when a short utterance is discarded
//   sample_lost         one-cycle pulse per sample arriving during DRAIN
//   state[1:0]          LISTEN=0, CAPTURE=1, DRAIN=2
//
// Optional build macro UTT_CAPTURE_LEN_EN adds:
//   utt_len[15:0]       length of the most recent drained utterance
//   utt_ready           one-cycle pulse on DRAIN entry
module utterance_capture_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int PRE_SAMPLES = 3200,
  parameter int MIN_SAMPLES = 1600,
  parameter int MAX_SAMPLES = 8000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [15:0]       audio_in,
  input  logic              speech_detected,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [15:0]       mem_rdata,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              utt_drop,
  output logic              sample_lost,
  output logic [1:0]        state
`ifdef UTT_CAPTURE_LEN_EN
  ,
  output logic [15:0]       utt_len,
  output logic              utt_ready
`endif
);

  localparam int                DATA_W  = 16;
  localparam logic [15:0]       PRE_L   = 16'(PRE_SAMPLES);
  localparam logic [15:0]       MIN_L   = 16'(MIN_SAMPLES);
  localparam logic [15:0]       MAX_L   = 16'(MAX_SAMPLES);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    LISTEN  = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                   st_q, st_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [15:0]              fill_q, fill_d;
  logic [15:0]              cap_len_q, cap_len_d;
  logic [15:0]              rd_cnt_q, rd_cnt_d;
  logic                     speech_q;
  logic                     drain_first_q, drain_first_d;
  logic                     drop_q, drop_d;
  logic                     vld_p1;
  logic                     vld_p2, vld_p2_d;
  logic signed [DATA_W-1:0] data_p2, data_p2_d;

  logic                     rise, fall, wr_en, rd_en, hs, last, drain_go;
  logic [ADDR_W-1:0]        rd_addr;
  logic [15:0]              pre_len, cap_cur;

  // History counter saturates at the pre-trigger depth.
  function automatic logic [15:0] sat_fill(input logic [15:0] f);
    return (f >= PRE_L) ? PRE_L : f + 16'd1;
  endfunction

  function automatic logic [15:0] clip_pre(input logic [15:0] f);
    return (f < PRE_L) ? f : PRE_L;
  endfunction

  always_comb begin
    st_d          = st_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    start_ptr_d   = start_ptr_q;
    cap_len_d     = cap_len_q;
    rd_ptr_d      = rd_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    drain_first_d = 1'b0;
    drop_d        = 1'b0;
    drain_go      = 1'b0;
    vld_p2_d      = vld_p2;
    data_p2_d     = data_p2;
    rise          = speech_detected & ~speech_q;
    fall          = ~speech_detected & speech_q;
    wr_en         = sample_valid & (st_q != DRAIN);
    hs            = vld_p2 & out_ready;
    last          = vld_p2 & (rd_cnt_q == 16'd1);
    rd_en         = 1'b0;
    rd_addr       = rd_ptr_q;
    pre_len       = clip_pre(fill_q);
    // Length including a sample written in this same cycle.
    cap_cur       = cap_len_q + {15'd0, sample_valid};

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      fill_d   = sat_fill(fill_q);
    end

    unique case (st_q)
      LISTEN: begin
        if (rise) begin
          st_d        = CAPTURE;
          start_ptr_d = wr_ptr_q - pre_len[ADDR_W-1:0];
          cap_len_d   = pre_len + {15'd0, sample_valid};
        end
      end
      CAPTURE: begin
        cap_len_d = cap_cur;
        // The cap is tested first so a simultaneous fall still drains.
        if (cap_cur >= MAX_L) begin
          drain_go = 1'b1;
        end else if (fall) begin
          if (cap_cur < MIN_L) begin
            drop_d = 1'b1;
            st_d   = LISTEN;
          end else begin
            drain_go = 1'b1;
          end
        end
        if (drain_go) begin
          st_d          = DRAIN;
          rd_ptr_d      = start_ptr_q;
          rd_cnt_d      = cap_cur;
          drain_first_d = 1'b1;
        end
      end
      DRAIN: begin
        // First read on entry; afterwards the next read is issued in the
        // handshake cycle so a sample costs two cycles end to end.
        rd_en = drain_first_q | (hs & ~last);
        if (vld_p1) begin
          vld_p2_d  = 1'b1;
          data_p2_d = $signed(mem_rdata);
        end
        if (hs) begin
          vld_p2_d = 1'b0;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          rd_cnt_d = rd_cnt_q - 16'd1;
          rd_addr  = rd_ptr_q + PTR_ONE;
          if (last) begin
            st_d   = LISTEN;
            fill_d = '0;
          end
        end
      end
      default: st_d = LISTEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= LISTEN;
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      cap_len_q     <= '0;
      rd_cnt_q      <= '0;
      speech_q      <= 1'b0;
      drain_first_q <= 1'b0;
      drop_q        <= 1'b0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      data_p2       <= '0;
    end else begin
      st_q          <= st_d;
      wr_ptr_q      <= wr_ptr_d;
      start_ptr_q   <= start_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      cap_len_q     <= cap_len_d;
      rd_cnt_q      <= rd_cnt_d;
      speech_q      <= speech_detected;
      drain_first_q <= drain_first_d;
      drop_q        <= drop_d;
      // p1: ring read in flight
      vld_p1        <= rd_en;
      // p2: read data captured and held until accepted
      vld_p2        <= vld_p2_d;
      data_p2       <= data_p2_d;
    end
  end

`ifdef UTT_CAPTURE_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      utt_len   <= '0;
      utt_ready <= 1'b0;
    end else begin
      utt_ready <= drain_go;
      if (drain_go) utt_len <= cap_cur;
    end
  end
`endif

  // Write strobe is forced low while reset is held so every output reads 0.
  assign mem_we      = wr_en & rst_n;
  assign mem_waddr   = wr_ptr_q;
  assign mem_wdata   = mem_we ? audio_in : 16'd0;
  assign mem_re      = rd_en;
  assign mem_raddr   = rd_addr;
  assign out_valid   = vld_p2;
  assign out_data    = data_p2;
  assign out_last    = last;
  assign busy        = (st_q != LISTEN);
  assign utt_drop    = drop_q;
  assign sample_lost = sample_valid & (st_q == DRAIN);
  assign state       = st_q;

endmodule

// File: tb/tb_utterance_capture_ctrl.sv
module tb_utterance_capture_ctrl;

  localparam int ADDR_W = 13;
  localparam int PRE    = 3200;
  localparam int MINL   = 1600;
  localparam int MAXL   = 8000;

  logic              clk, rst_n, sample_valid, speech_detected, out_ready;
  logic [15:0]       audio_in, mem_rdata;
  logic              mem_we, mem_re, out_valid, out_last, busy, utt_drop, sample_lost;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [15:0]       mem_wdata, out_data;
  logic [1:0]        state;
`ifdef UTT_CAPTURE_LEN_EN
  logic [15:0]       utt_len;
  logic              utt_ready;
`endif

  utterance_capture_ctrl #(
    .ADDR_W(ADDR_W), .PRE_SAMPLES(PRE), .MIN_SAMPLES(MINL), .MAX_SAMPLES(MAXL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .audio_in(audio_in),
    .speech_detected(speech_detected), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .utt_drop(utt_drop),
    .sample_lost(sample_lost), .state(state)
`ifdef UTT_CAPTURE_LEN_EN
    , .utt_len(utt_len), .utt_ready(utt_ready)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ring memory, one cycle read latency.
  logic [15:0] ring [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) ring[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ring[mem_raddr];
  end

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   wcount, fillm;
  int   drop_exp = 0, drop_seen = 0, lost_exp = 0, lost_seen = 0;
  int   pop_idx = 0;
  bit   rand_ready = 0;
  bit   stall_pend = 0;
  logic [15:0] stall_data;

  function automatic logic [15:0] val(input int idx);
    return 16'(idx) ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready: held high, or random with 3/4 probability when enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each accepted stream sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (utt_drop) drop_seen++;
      if (sample_lost) lost_seen++;
      if (stall_pend) begin
        checks++;
        if (!out_valid || out_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: got valid %b data %h expected valid 1 data %h",
                   out_valid, out_data, stall_data);
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got data %h last %b expected no output", out_data, out_last);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_last !== mon_e.last) begin
            errors++;
            $display("FAIL stream[%0d]: got data %h last %b expected data %h last %b",
                     pop_idx, out_data, out_last, mon_e.data, mon_e.last);
          end
          pop_idx++;
        end
      end
    end else begin
      stall_pend = 0;
    end
  end

  task automatic push_utt(input int start, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.data = val(start + k);
      e.last = (k == len - 1);
      sb.push_back(e);
    end
    fillm = 0;
  endtask

  task automatic feed(input int n, input logic sp);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1; speech_detected = sp; audio_in = val(wcount);
      @(posedge clk); #1;
      wcount++;
      fillm = (fillm >= PRE) ? PRE : fillm + 1;
    end
    sample_valid = 1'b0;
  endtask

  // Rise with a sample, n samples total with speech high, then a fall cycle.
  task automatic capture(input int n);
    int pre, start, cap;
    bit capped;
    pre = (fillm < PRE) ? fillm : PRE;
    start = wcount - pre;
    cap = pre;
    capped = 0;
    for (int i = 0; i < n; i++) begin
      speech_detected = 1'b1; sample_valid = 1'b1;
      audio_in = capped ? 16'hDEAD : val(wcount);
      @(posedge clk); #1;
      if (!capped) begin
        wcount++;
        fillm = (fillm >= PRE) ? PRE : fillm + 1;
        cap++;
        if (i == 0) chk("capture_entry_state", 32'(state), 32'd1);
        if (cap == MAXL) begin
          capped = 1;
          push_utt(start, cap);
          chk("cap_drain_state", 32'(state), 32'd2);
        end
      end else begin
        lost_exp++;
      end
    end
    sample_valid = 1'b0; speech_detected = 1'b0;
    @(posedge clk); #1;
    if (!capped) begin
      if (cap < MINL) begin
        drop_exp++;
        chk("drop_state", 32'(state), 32'd0);
      end else begin
        push_utt(start, cap);
        chk("drain_state", 32'(state), 32'd2);
        chk("drain_busy", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n, quiet;
    n = 0; quiet = 0;
    while (!(sb.size() == 0 && state == 2'd0 && !out_valid) && n < budget && quiet < 20) begin
      @(posedge clk); #1;
      n++;
      quiet = (state == 2'd0 && !out_valid) ? quiet + 1 : 0;
    end
    chk({name, "_left"}, 32'(sb.size()), 32'd0);
    chk({name, "_state"}, 32'(state), 32'd0);
    sb.delete();
  endtask

  task automatic check_counts(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_drops"}, 32'(drop_seen), 32'(drop_exp));
    chk({name, "_lost"}, 32'(lost_seen), 32'(lost_exp));
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({name, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({name, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({name, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_out_data"}, 32'(out_data), 32'd0);
    chk({name, "_out_last"}, 32'(out_last), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_utt_drop"}, 32'(utt_drop), 32'd0);
    chk({name, "_sample_lost"}, 32'(sample_lost), 32'd0);
    chk({name, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; sample_valid = 1'b0; audio_in = 16'h7FFF; speech_detected = 1'b0;
    wcount = 0; fillm = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal utterance: 3200 history + rise sample + 2000 = 5201.
    feed(4000, 1'b0);
    capture(2001);
    wait_idle(20000, "normal");
    check_counts("normal");

    // Long enough with full history, then too short with history cleared.
    feed(3200, 1'b0);
    capture(101);
    wait_idle(10000, "short_ok");
    capture(100);
    wait_idle(100, "short_drop");
    check_counts("short");

    // Length cap: drains at exactly 8000, the rest of the samples are lost.
    feed(3200, 1'b0);
    capture(10000);
    wait_idle(40000, "cap");
    check_counts("cap");

    // Wrap across address 0 with random backpressure.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    wcount = 0; fillm = 0;
    feed(8190, 1'b0);
    rand_ready = 1;
    capture(1000);
    wait_idle(40000, "wrap");
    rand_ready = 0;
    check_counts("wrap");

    // Reset in the middle of a stream, then an early trigger afterwards.
    feed(2000, 1'b0);
    capture(2000);
    n = 0;
    while (sb.size() > 3990 && n < 2000) begin @(posedge clk); #1; n++; end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    sb.delete();
    wcount = 0; fillm = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(100, 1'b0);
    capture(2000);
    wait_idle(10000, "early");
    check_counts("early");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
